// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: takes one load/store request from the pipeline. It issues one or
// two word-aligned, byte-lane-enabled bus beats. It then returns load data
// that is sign- or zero-extended per MemType/MemSign. The unit is busy
// (Ready_o=0) from the cycle after a request is accepted until the cycle
// after Done_o.
//
// Optional feature macro: MISALIGNED_SPLIT_EN
//   defined   - accesses crossing a word boundary run as two beats
//   undefined - such accesses pulse MisalignErr_o and never touch the bus
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   Req_i                 request valid, sampled only while Ready_o=1
//   MemWrite_i            1=store, 0=load
//   MemType_i             00/11=word, 01=byte, 10=half
//   MemSign_i             0=sign-extend, 1=zero-extend loads
//   Addr_i, WriteData_i   byte address and right-aligned store data
//   Ready_o, Done_o       idle indication, one-cycle completion pulse
//   ReadData_o            extended load data (0 after a store)
//   MisalignErr_o         one-cycle pulse on a rejected misaligned access
//   BusReq_o..BusWData_o  bus beat request, held stable until BusAck_i
//   BusAck_i, BusRData_i  beat accept, read word valid with the ack
//
// The internal datapath is fixed at 32 bits; DATA_WIDTH must be 32.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    Req_i,
    input  logic                    MemWrite_i,
    input  logic [1:0]              MemType_i,
    input  logic                    MemSign_i,
    input  logic [DATA_WIDTH-1:0]   Addr_i,
    input  logic [DATA_WIDTH-1:0]   WriteData_i,
    output logic                    Ready_o,
    output logic                    Done_o,
    output logic [DATA_WIDTH-1:0]   ReadData_o,
    output logic                    MisalignErr_o,
    output logic                    BusReq_o,
    output logic                    BusWe_o,
    output logic [DATA_WIDTH-1:0]   BusAddr_o,
    output logic [3:0]              BusBe_o,
    output logic [DATA_WIDTH-1:0]   BusWData_o,
    input  logic                    BusAck_i,
    input  logic [DATA_WIDTH-1:0]   BusRData_i
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [63:0] buf_q, buf_d;

    // Latched request fields
    logic [29:0] word_q, word_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  type_q, type_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic        split_q, split_d;
    logic [31:0] wdata_q, wdata_d;

    // Lane helpers
    logic [1:0]  src_off;
    logic [1:0]  src_type;
    logic [31:0] src_wdata;
    logic [2:0]  req_end;
    logic        req_split;
    logic [7:0]  be_lanes;
    logic [63:0] wd_lanes;
    logic [63:0] rd_full;
    logic [31:0] rd_word;
    logic        finish;
    logic        split_ok;

`ifdef MISALIGNED_SPLIT_EN
    assign split_ok = 1'b1;
`else
    assign split_ok = 1'b0;
`endif

    function automatic logic [3:0] size_mask(input logic [1:0] mtype);
        logic [3:0] m;
        case (mtype)
            2'b01:   m = 4'b0001;
            2'b10:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] mtype);
        logic [2:0] n;
        case (mtype)
            2'b01:   n = 3'd1;
            2'b10:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  mtype,
                                                input logic        zext);
        logic [31:0] res;
        case (mtype)
            2'b01:   res = zext ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b10:   res = zext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // The lanes of both beats come from one 8-lane / 64-bit shift. The low
    // half drives ACC0 and the high half drives ACC1. While idle, the shift
    // source is the live request, so the first beat can be registered at
    // acceptance.
    always_comb begin
        src_off   = (state_q == IDLE) ? Addr_i[1:0] : off_q;
        src_type  = (state_q == IDLE) ? MemType_i   : type_q;
        src_wdata = (state_q == IDLE) ? WriteData_i : wdata_q;
        req_end   = {1'b0, Addr_i[1:0]} + size_bytes(MemType_i);
        req_split = (req_end > 3'd4);
        be_lanes  = {4'b0000, size_mask(src_type)} << src_off;
        wd_lanes  = {32'h0, src_wdata} << {src_off, 3'b000};
        // The final ack's word is merged with the buffer so the result is
        // ready in the same edge that captures it.
        rd_full   = (state_q == ACC1) ? {BusRData_i, buf_q[31:0]}
                                      : {buf_q[63:32], BusRData_i};
        rd_word   = 32'(rd_full >> {off_q, 3'b000});
    end

    // Next-state logic; every output is a flop updated from here.
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        buf_d       = buf_q;
        word_d      = word_q;
        off_d       = off_q;
        type_d      = type_q;
        sign_d      = sign_q;
        we_d        = we_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req_i) begin
                    word_d  = Addr_i[31:2];
                    off_d   = Addr_i[1:0];
                    type_d  = MemType_i;
                    sign_d  = MemSign_i;
                    we_d    = MemWrite_i;
                    wdata_d = WriteData_i;
                    split_d = req_split;
                    if (req_split && !split_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ACC0;
                        ready_d     = 1'b0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite_i;
                        bus_addr_d  = {Addr_i[31:2], 2'b00};
                        bus_be_d    = be_lanes[3:0];
                        bus_wdata_d = wd_lanes[31:0];
                    end
                end
            end
            ACC0: begin
                if (BusAck_i) begin
                    buf_d[31:0] = BusRData_i;
                    if (split_q) begin
                        state_d     = ACC1;
                        bus_addr_d  = {word_q + 30'd1, 2'b00};
                        bus_be_d    = be_lanes[7:4];
                        bus_wdata_d = wd_lanes[63:32];
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ACC1: begin
                if (BusAck_i) begin
                    buf_d[63:32] = BusRData_i;
                    finish       = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (finish) begin
            state_d   = RESP;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
            bus_be_d  = 4'b0000;
            done_d    = 1'b1;
            rdata_d   = we_q ? 32'h0 : extend_load(rd_word, type_q, sign_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            buf_q       <= 64'h0;
            word_q      <= 30'h0;
            off_q       <= 2'b00;
            type_q      <= 2'b00;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            buf_q       <= buf_d;
            word_q      <= word_d;
            off_q       <= off_d;
            type_q      <= type_d;
            sign_q      <= sign_d;
            we_q        <= we_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
        end
    end

    assign Ready_o       = ready_q;
    assign Done_o        = done_q;
    assign MisalignErr_o = err_q;
    assign ReadData_o    = rdata_q;
    assign BusReq_o      = bus_req_q;
    assign BusWe_o       = bus_we_q;
    assign BusAddr_o     = bus_addr_q;
    assign BusBe_o       = bus_be_q;
    assign BusWData_o    = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Testbench for load_store_unit. A table of requests is applied in a loop.
// A bus responder checks each expected beat and acks it after a
// programmable number of wait cycles. A completion scoreboard compares
// Done_o / MisalignErr_o / ReadData_o. Hand-written sequences then cover
// an asynchronous reset in the middle of an access.
// Split-dependent expectations follow MISALIGNED_SPLIT_EN.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk_i;
    logic        rst_n_i;
    logic        Req_i;
    logic        MemWrite_i;
    logic [1:0]  MemType_i;
    logic        MemSign_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        Ready_o;
    logic        Done_o;
    logic [31:0] ReadData_o;
    logic        MisalignErr_o;
    logic        BusReq_o;
    logic        BusWe_o;
    logic [31:0] BusAddr_o;
    logic [3:0]  BusBe_o;
    logic [31:0] BusWData_o;
    logic        BusAck_i;
    logic [31:0] BusRData_i;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .Req_i         (Req_i),
        .MemWrite_i    (MemWrite_i),
        .MemType_i     (MemType_i),
        .MemSign_i     (MemSign_i),
        .Addr_i        (Addr_i),
        .WriteData_i   (WriteData_i),
        .Ready_o       (Ready_o),
        .Done_o        (Done_o),
        .ReadData_o    (ReadData_o),
        .MisalignErr_o (MisalignErr_o),
        .BusReq_o      (BusReq_o),
        .BusWe_o       (BusWe_o),
        .BusAddr_o     (BusAddr_o),
        .BusBe_o       (BusBe_o),
        .BusWData_o    (BusWData_o),
        .BusAck_i      (BusAck_i),
        .BusRData_i    (BusRData_i)
    );

    // Request record: inputs, expected beats, expected completion
    typedef struct {
        logic        we;
        logic [1:0]  mtype;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_wait;
        logic        noise;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] rd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rd1;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } comp_t;

    beat_t beat_q[$];
    comp_t comp_q[$];
    beat_t resp_beat;
    comp_t mon_exp;
    vec_t  vecs[13];

    int total;
    int bad;
    int ack_wait;
    int wait_cnt;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Bus responder: checks the pending beat every cycle it is requested,
    // which also proves the beat fields stay stable while waiting.
    initial begin
        BusAck_i   = 1'b0;
        BusRData_i = 32'h0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk_i);
            if (BusAck_i) begin
                BusAck_i = 1'b0;
                wait_cnt = 0;
            end
            if (!BusReq_o) begin
                wait_cnt = 0;
            end else if (beat_q.size() == 0) begin
                checkOutput("bus_req_unexpected", 64'(BusReq_o), 64'd0);
            end else begin
                resp_beat = beat_q[0];
                checkOutput("beat_addr", 64'(BusAddr_o), 64'(resp_beat.addr));
                checkOutput("beat_be", 64'(BusBe_o), 64'(resp_beat.be));
                checkOutput("beat_we", 64'(BusWe_o), 64'(resp_beat.we));
                if (resp_beat.we)
                    checkOutput("beat_wdata", 64'(BusWData_o), 64'(resp_beat.wdata));
                if (wait_cnt >= ack_wait) begin
                    BusRData_i = resp_beat.rdata;
                    BusAck_i   = 1'b1;
                    resp_beat  = beat_q.pop_front();
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Completion scoreboard
    initial begin
        forever begin
            @(negedge clk_i);
            if (Done_o || MisalignErr_o) begin
                if (comp_q.size() == 0) begin
                    checkOutput("completion_unexpected", 64'({Done_o, MisalignErr_o}), 64'd0);
                end else begin
                    mon_exp = comp_q.pop_front();
                    checkOutput("misalign_err", 64'(MisalignErr_o), 64'(mon_exp.err));
                    if (!mon_exp.err)
                        checkOutput("read_data", 64'(ReadData_o), 64'(mon_exp.rdata));
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int    cnt;
        int    lat;
        logic  seen;
        beat_t b;
        comp_t c;
        cnt = 0;
        while (!Ready_o && cnt < 50) begin
            @(negedge clk_i);
            cnt++;
        end
        ack_wait = v.ack_wait;
        if (v.nbeats >= 1) begin
            b = '{v.a0, v.be0, v.we, v.wd0, v.rd0};
            beat_q.push_back(b);
        end
        if (v.nbeats == 2) begin
            b = '{v.a1, v.be1, v.we, v.wd1, v.rd1};
            beat_q.push_back(b);
        end
        c = '{v.err, v.rdata};
        comp_q.push_back(c);
        lat = v.err ? 1 : (2 + (v.nbeats - 1) + v.ack_wait * v.nbeats);

        Req_i       = 1'b1;
        MemWrite_i  = v.we;
        MemType_i   = v.mtype;
        MemSign_i   = v.sign;
        Addr_i      = v.addr;
        WriteData_i = v.wdata;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 60) begin
            @(negedge clk_i);
            cnt++;
            // Optional Req_i pulses while busy must be ignored
            Req_i = v.noise && (cnt == 2 || cnt == 3);
            if (Done_o || MisalignErr_o)
                seen = 1'b1;
        end
        Req_i = 1'b0;
        checkOutput("latency", 64'(cnt), 64'(lat));
        @(negedge clk_i);
        checkOutput("ready_after", 64'(Ready_o), 64'd1);
        checkOutput("beats_left", 64'(beat_q.size()), 64'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        ack_wait    = 0;
        rst_n_i     = 1'b0;
        Req_i       = 1'b0;
        MemWrite_i  = 1'b0;
        MemType_i   = 2'b00;
        MemSign_i   = 1'b0;
        Addr_i      = 32'h0;
        WriteData_i = 32'h0;

        // we mtype sign addr wdata wait noise nbeats
        //   a0 be0 wd0 rd0   a1 be1 wd1 rd1   err rdata
        vecs[0]  = '{1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 1'b0, 1,
                     32'h100, 4'b1000, 32'h0, 32'h80FFFF00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 0, 1'b0, 1,
                     32'h100, 4'b1000, 32'h0, 32'h80FFFF00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h00000080};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h202, 32'h0000BEEF, 0, 1'b0, 1,
                     32'h200, 4'b1100, 32'hBEEF0000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1'b0, 1,
                     32'h100, 4'b1100, 32'h0, 32'h80012345, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF8001};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 0, 1'b0, 1,
                     32'h400, 4'b1111, 32'h0, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h501, 32'h000000A5, 0, 1'b0, 1,
                     32'h500, 4'b0010, 32'h0000A500, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 2'b11, 1'b0, 32'h600, 32'h12345678, 0, 1'b0, 1,
                     32'h600, 4'b1111, 32'h12345678, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h700, 32'hCAFEF00D, 3, 1'b1, 1,
                     32'h700, 4'b1111, 32'hCAFEF00D, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 1, 1'b0, 1,
                     32'h000, 4'b0001, 32'h0, 32'h123456FE, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h000000FE};
        vecs[12] = '{1'b0, 2'b10, 1'b1, 32'h002, 32'h0, 0, 1'b0, 1,
                     32'h000, 4'b1100, 32'h0, 32'hF00D0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0000F00D};
`ifdef MISALIGNED_SPLIT_EN
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 0, 1'b0, 2,
                     32'h300, 4'b1110, 32'h0, 32'h44332211, 32'h304, 4'b0001, 32'h0, 32'h88776655, 1'b0, 32'h55443322};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h003, 32'h0, 0, 1'b0, 2,
                     32'h000, 4'b1000, 32'h0, 32'hAB000000, 32'h004, 4'b0001, 32'h0, 32'h000000CD, 1'b0, 32'hFFFFCDAB};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h702, 32'h11223344, 0, 1'b0, 2,
                     32'h700, 4'b1100, 32'h33440000, 32'h0, 32'h704, 4'b0011, 32'h00001122, 32'h0, 1'b0, 32'h0};
`else
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 0, 1'b0, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h003, 32'h0, 0, 1'b0, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h702, 32'h11223344, 0, 1'b0, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0};
`endif

        repeat (2) @(negedge clk_i);
        checkOutput("rst_ready", 64'(Ready_o), 64'd1);
        checkOutput("rst_done", 64'(Done_o), 64'd0);
        checkOutput("rst_err", 64'(MisalignErr_o), 64'd0);
        checkOutput("rst_busreq", 64'(BusReq_o), 64'd0);
        checkOutput("rst_buswe", 64'(BusWe_o), 64'd0);
        checkOutput("rst_busaddr", 64'(BusAddr_o), 64'd0);
        checkOutput("rst_busbe", 64'(BusBe_o), 64'd0);
        checkOutput("rst_buswdata", 64'(BusWData_o), 64'd0);
        checkOutput("rst_rdata", 64'(ReadData_o), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i]);

        // Asynchronous reset in ACC0 with the ack withheld
        ack_wait = 1000;
        resp_beat = '{32'h800, 4'b1111, 1'b0, 32'h0, 32'h0};
        beat_q.push_back(resp_beat);
        Req_i       = 1'b1;
        MemWrite_i  = 1'b0;
        MemType_i   = 2'b00;
        MemSign_i   = 1'b0;
        Addr_i      = 32'h800;
        @(negedge clk_i);
        Req_i = 1'b0;
        checkOutput("abort_busreq_up", 64'(BusReq_o), 64'd1);
        #2 rst_n_i = 1'b0;
        #1 checkOutput("abort_busreq_drop", 64'(BusReq_o), 64'd0);
        beat_q.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput("abort_no_done", 64'(Done_o), 64'd0);
        end
        checkOutput("abort_ready", 64'(Ready_o), 64'd1);

        // Recovery after the abort
        applyStimulus(vecs[5]);
        checkOutput("comps_left", 64'(comp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
